// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared encodings for the hazard controller: opcode width and the opcodes
// the controller recognises, the FSM state encoding (also driven onto the
// debug state port), and the operand-forwarding select codes.
package hazard_ctrl_pkg;

    localparam int OPCODE_WIDTH = 7;

    localparam logic [OPCODE_WIDTH-1:0] LOAD_WORD = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD    = 7'b0110011;

    typedef enum logic [1:0] {
        HZ_IDLE     = 2'b00,
        HZ_MEM_WAIT = 2'b01,
        HZ_FLUSH    = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// hazard_fwd_unit
// Purely combinational per-operand comparator. One instance serves one source
// operand: it picks the forwarding source for the execute-stage operand and
// flags whether the decode-stage operand reads a register that EX, MEM or WB
// is about to write (register 0 never matches).
// Ports:
//   ex_rs            execute-stage source address (forwarding side)
//   de_rs, de_use    decode-stage source address and its use flag (RAW side)
//   ex_rd, ex_wr     EX destination and "EX holds a valid writing instruction"
//   mem_rd, mem_we   MEM destination and write enable
//   wb_rd, wb_we     WB destination and write enable
//   fwd_sel          00 regfile, 01 MEM result, 10 WB result (MEM wins)
//   raw_ex/mem/wb    decode operand matches a pending write in that stage
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int AWIDTH = 5
) (
    input  logic [AWIDTH-1:0] ex_rs,
    input  logic [AWIDTH-1:0] de_rs,
    input  logic              de_use,
    input  logic [AWIDTH-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic [AWIDTH-1:0] mem_rd,
    input  logic              mem_we,
    input  logic [AWIDTH-1:0] wb_rd,
    input  logic              wb_we,
    output logic [1:0]        fwd_sel,
    output logic              raw_ex,
    output logic              raw_mem,
    output logic              raw_wb
);

    logic mem_fwd;
    logic wb_fwd;

    assign mem_fwd = mem_we && (mem_rd != '0) && (mem_rd == ex_rs);
    assign wb_fwd  = wb_we  && (wb_rd  != '0) && (wb_rd  == ex_rs);
    assign fwd_sel = mem_fwd ? FWD_MEM : (wb_fwd ? FWD_WB : FWD_RF);

    assign raw_ex  = de_use && ex_wr  && (ex_rd  != '0) && (ex_rd  == de_rs);
    assign raw_mem = de_use && mem_we && (mem_rd != '0) && (mem_rd == de_rs);
    assign raw_wb  = de_use && wb_we  && (wb_rd  != '0) && (wb_rd  == de_rs);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard and sequencing controller for the 5-stage core. Detects
// load-use / RAW hazards, drives per-stage stall and flush lines, produces
// operand-forwarding selects, holds the pipe during outstanding data-memory
// accesses (with a timeout), and turns a PC change into a bounded front-end
// flush.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding
// (only load-use then inserts a bubble). Without it the forwarding selects
// are 00 and any RAW match against EX/MEM/WB stalls decode in IDLE.
// Ports:
//   hz_clk, hz_rst                    clock, async active-high reset
//   hz_i_de_*                         decode valid, sources, source-use flags
//   hz_i_ex_*                         execute valid, opcode, sources, rd, we,
//                                     PC redirect
//   hz_i_mem_rd/we, hz_i_wb_rd/we     pending writes in MEM / WB
//   hz_i_mem_req, hz_i_mem_ack        data-memory request / completion
//   hz_o_stall_if/de/ex               hold stage registers
//   hz_o_flush_de/ex                  bubble stage contents
//   hz_o_fwd_rs1/rs2                  forwarding selects
//   hz_o_timeout                      one-cycle memory-timeout pulse
//   hz_o_state                        FSM state (debug)
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int AWIDTH       = 5,
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    hz_clk,
    input  logic                    hz_rst,
    input  logic                    hz_i_de_ce,
    input  logic [AWIDTH-1:0]       hz_i_de_rs1,
    input  logic [AWIDTH-1:0]       hz_i_de_rs2,
    input  logic                    hz_i_de_use_rs1,
    input  logic                    hz_i_de_use_rs2,
    input  logic                    hz_i_ex_ce,
    input  logic [OPCODE_WIDTH-1:0] hz_i_ex_opcode,
    input  logic [AWIDTH-1:0]       hz_i_ex_rs1,
    input  logic [AWIDTH-1:0]       hz_i_ex_rs2,
    input  logic [AWIDTH-1:0]       hz_i_ex_rd,
    input  logic                    hz_i_ex_we,
    input  logic                    hz_i_ex_change_pc,
    input  logic [AWIDTH-1:0]       hz_i_mem_rd,
    input  logic [AWIDTH-1:0]       hz_i_wb_rd,
    input  logic                    hz_i_mem_we,
    input  logic                    hz_i_wb_we,
    input  logic                    hz_i_mem_req,
    input  logic                    hz_i_mem_ack,
    output logic                    hz_o_stall_if,
    output logic                    hz_o_stall_de,
    output logic                    hz_o_stall_ex,
    output logic                    hz_o_flush_de,
    output logic                    hz_o_flush_ex,
    output logic [1:0]              hz_o_fwd_rs1,
    output logic [1:0]              hz_o_fwd_rs2,
    output logic                    hz_o_timeout,
    output logic [1:0]              hz_o_state
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    // Last MEM_WAIT count: incrementing past it would reach MEM_TIMEOUT-1,
    // which together with the request cycle makes MEM_TIMEOUT stall cycles.
    localparam logic [CW-1:0] MEM_LAST   = CW'(MEM_TIMEOUT - 2);
    localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES);

    hz_state_e     state;
    logic [CW-1:0] mem_cnt;
    logic [2:0]    flush_cnt;
    logic          pend;

    logic [1:0] fwd_sel1, fwd_sel2;
    logic       raw_ex1, raw_mem1, raw_wb1;
    logic       raw_ex2, raw_mem2, raw_wb2;
    logic       ex_wr;
    logic       load_use;
    logic       bubble;
    logic [1:0] fwd1, fwd2;
    logic       req_wait;
    logic       mem_last;

    assign ex_wr = hz_i_ex_ce && hz_i_ex_we;

    hazard_fwd_unit #(.AWIDTH(AWIDTH)) u_fwd_rs1 (
        .ex_rs   (hz_i_ex_rs1),
        .de_rs   (hz_i_de_rs1),
        .de_use  (hz_i_de_use_rs1),
        .ex_rd   (hz_i_ex_rd),
        .ex_wr   (ex_wr),
        .mem_rd  (hz_i_mem_rd),
        .mem_we  (hz_i_mem_we),
        .wb_rd   (hz_i_wb_rd),
        .wb_we   (hz_i_wb_we),
        .fwd_sel (fwd_sel1),
        .raw_ex  (raw_ex1),
        .raw_mem (raw_mem1),
        .raw_wb  (raw_wb1)
    );

    hazard_fwd_unit #(.AWIDTH(AWIDTH)) u_fwd_rs2 (
        .ex_rs   (hz_i_ex_rs2),
        .de_rs   (hz_i_de_rs2),
        .de_use  (hz_i_de_use_rs2),
        .ex_rd   (hz_i_ex_rd),
        .ex_wr   (ex_wr),
        .mem_rd  (hz_i_mem_rd),
        .mem_we  (hz_i_mem_we),
        .wb_rd   (hz_i_wb_rd),
        .wb_we   (hz_i_wb_we),
        .fwd_sel (fwd_sel2),
        .raw_ex  (raw_ex2),
        .raw_mem (raw_mem2),
        .raw_wb  (raw_wb2)
    );

    // raw_ex already folds in EX valid, EX write enable and rd != 0.
    assign load_use = hz_i_de_ce && (hz_i_ex_opcode == LOAD_WORD) && (raw_ex1 || raw_ex2);

`ifdef HAZARD_FORWARDING_EN
    logic unused_raw;
    assign unused_raw = &{1'b0, raw_mem1, raw_wb1, raw_mem2, raw_wb2};
    assign bubble = load_use;
    assign fwd1   = fwd_sel1;
    assign fwd2   = fwd_sel2;
`else
    logic unused_fwd;
    assign unused_fwd = &{1'b0, fwd_sel1, fwd_sel2};
    assign bubble = load_use || (hz_i_de_ce &&
                    (raw_ex1 || raw_mem1 || raw_wb1 || raw_ex2 || raw_mem2 || raw_wb2));
    assign fwd1   = FWD_RF;
    assign fwd2   = FWD_RF;
`endif

    assign req_wait = hz_i_mem_req && !hz_i_mem_ack;
    assign mem_last = (mem_cnt == MEM_LAST) && !hz_i_mem_ack;

    always_ff @(posedge hz_clk or posedge hz_rst) begin
        if (hz_rst) begin
            state     <= HZ_IDLE;
            mem_cnt   <= '0;
            flush_cnt <= '0;
            pend      <= 1'b0;
        end else begin
            case (state)
                HZ_IDLE: begin
                    if (req_wait) begin
                        state   <= HZ_MEM_WAIT;
                        mem_cnt <= '0;
                        pend    <= 1'b0;
                    end else if (hz_i_ex_change_pc) begin
                        state     <= HZ_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                HZ_MEM_WAIT: begin
                    if (hz_i_mem_ack || mem_last) begin
                        // A redirect seen while waiting is honoured on exit.
                        if (pend || hz_i_ex_change_pc) begin
                            state     <= HZ_FLUSH;
                            flush_cnt <= FLUSH_LOAD;
                        end else begin
                            state <= HZ_IDLE;
                        end
                        pend    <= 1'b0;
                        mem_cnt <= '0;
                    end else begin
                        mem_cnt <= mem_cnt + CW'(1);
                        if (hz_i_ex_change_pc) pend <= 1'b1;
                    end
                end
                HZ_FLUSH: begin
                    if (hz_i_ex_change_pc) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (flush_cnt <= 3'd1) begin
                        state     <= HZ_IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= HZ_IDLE;
                    mem_cnt   <= '0;
                    flush_cnt <= '0;
                    pend      <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are forced low during reset, including the combinational paths.
    always_comb begin
        hz_o_stall_if = 1'b0;
        hz_o_stall_de = 1'b0;
        hz_o_stall_ex = 1'b0;
        hz_o_flush_de = 1'b0;
        hz_o_flush_ex = 1'b0;
        hz_o_timeout  = 1'b0;
        if (!hz_rst) begin
            case (state)
                HZ_IDLE: begin
                    // A new memory wait outranks a bubble: no flush while EX is held.
                    hz_o_stall_if = req_wait || bubble;
                    hz_o_stall_de = req_wait || bubble;
                    hz_o_stall_ex = req_wait;
                    hz_o_flush_ex = bubble && !req_wait;
                end
                HZ_MEM_WAIT: begin
                    hz_o_stall_if = 1'b1;
                    hz_o_stall_de = 1'b1;
                    hz_o_stall_ex = 1'b1;
                    hz_o_timeout  = mem_last;
                end
                HZ_FLUSH: begin
                    hz_o_flush_de = 1'b1;
                    hz_o_flush_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz_o_fwd_rs1 = hz_rst ? FWD_RF : fwd1;
    assign hz_o_fwd_rs2 = hz_rst ? FWD_RF : fwd2;
    assign hz_o_state   = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the controller.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int AWIDTH       = 5;
    localparam int MEM_TIMEOUT  = 16;
    localparam int FLUSH_CYCLES = 2;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                    clk;
    logic                    rst;
    logic                    de_ce;
    logic [AWIDTH-1:0]       de_rs1, de_rs2;
    logic                    use_rs1, use_rs2;
    logic                    ex_ce;
    logic [OPCODE_WIDTH-1:0] ex_op;
    logic [AWIDTH-1:0]       ex_rs1, ex_rs2, ex_rd;
    logic                    ex_we;
    logic                    change_pc;
    logic [AWIDTH-1:0]       mem_rd, wb_rd;
    logic                    mem_we, wb_we;
    logic                    mem_req, mem_ack;
    logic                    stall_if, stall_de, stall_ex;
    logic                    flush_de, flush_ex;
    logic [1:0]              fwd_rs1, fwd_rs2;
    logic                    timeout;
    logic [1:0]              state;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(
        .AWIDTH(AWIDTH), .MEM_TIMEOUT(MEM_TIMEOUT), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .hz_clk            (clk),
        .hz_rst            (rst),
        .hz_i_de_ce        (de_ce),
        .hz_i_de_rs1       (de_rs1),
        .hz_i_de_rs2       (de_rs2),
        .hz_i_de_use_rs1   (use_rs1),
        .hz_i_de_use_rs2   (use_rs2),
        .hz_i_ex_ce        (ex_ce),
        .hz_i_ex_opcode    (ex_op),
        .hz_i_ex_rs1       (ex_rs1),
        .hz_i_ex_rs2       (ex_rs2),
        .hz_i_ex_rd        (ex_rd),
        .hz_i_ex_we        (ex_we),
        .hz_i_ex_change_pc (change_pc),
        .hz_i_mem_rd       (mem_rd),
        .hz_i_wb_rd        (wb_rd),
        .hz_i_mem_we       (mem_we),
        .hz_i_wb_we        (wb_we),
        .hz_i_mem_req      (mem_req),
        .hz_i_mem_ack      (mem_ack),
        .hz_o_stall_if     (stall_if),
        .hz_o_stall_de     (stall_de),
        .hz_o_stall_ex     (stall_ex),
        .hz_o_flush_de     (flush_de),
        .hz_o_flush_ex     (flush_ex),
        .hz_o_fwd_rs1      (fwd_rs1),
        .hz_o_fwd_rs2      (fwd_rs2),
        .hz_o_timeout      (timeout),
        .hz_o_state        (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {stall_if, stall_de, stall_ex, flush_de, flush_ex, timeout};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_idle();
        de_ce = 0; de_rs1 = 0; de_rs2 = 0; use_rs1 = 0; use_rs2 = 0;
        ex_ce = 0; ex_op = OP_ADD; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_we = 0;
        change_pc = 0; mem_rd = 0; wb_rd = 0; mem_we = 0; wb_we = 0;
        mem_req = 0; mem_ack = 0;
    endtask

    task automatic drive_random(input bit allow_ack);
        de_ce   = 1'($urandom_range(0, 1));
        de_rs1  = 5'($urandom_range(0, 7));
        de_rs2  = 5'($urandom_range(0, 7));
        use_rs1 = 1'($urandom_range(0, 1));
        use_rs2 = 1'($urandom_range(0, 1));
        ex_ce   = 1'($urandom_range(0, 1));
        ex_op   = ($urandom_range(0, 1) == 0) ? LOAD_WORD : OP_ADD;
        ex_rs1  = 5'($urandom_range(0, 7));
        ex_rs2  = 5'($urandom_range(0, 7));
        ex_rd   = 5'($urandom_range(0, 7));
        ex_we   = 1'($urandom_range(0, 1));
        mem_rd  = 5'($urandom_range(0, 7));
        wb_rd   = 5'($urandom_range(0, 7));
        mem_we  = 1'($urandom_range(0, 1));
        wb_we   = 1'($urandom_range(0, 1));
        change_pc = ($urandom_range(0, 9) == 0);
        mem_req   = ($urandom_range(0, 7) == 0);
        mem_ack   = allow_ack && ($urandom_range(0, 3) == 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // m_stalls: memory-hold stall cycles so far including the request cycle
    // (0 when no access is outstanding); m_flush_left: flush cycles still owed.
    int m_stalls = 0, n_stalls = 0;
    int m_flush_left = 0, n_flush_left = 0;
    bit m_pend = 0, n_pend = 0;

    function automatic bit hits(input logic [AWIDTH-1:0] rs, input logic use_it,
                                input logic [AWIDTH-1:0] rd, input logic wr);
        return use_it && wr && (rd != 0) && (rs == rd);
    endfunction

    function automatic bit exp_bubble();
        logic [AWIDTH-1:0] rds[3];
        bit                wrs[3];
        bit                raw;
        bit                lu;
        rds[0] = ex_rd;  wrs[0] = ex_ce && ex_we;
        rds[1] = mem_rd; wrs[1] = mem_we;
        rds[2] = wb_rd;  wrs[2] = wb_we;
        lu = de_ce && ex_ce && (ex_op == LOAD_WORD) &&
             (hits(de_rs1, use_rs1, ex_rd, ex_we) || hits(de_rs2, use_rs2, ex_rd, ex_we));
        raw = 0;
        for (int s = 0; s < 3; s++)
            if (hits(de_rs1, use_rs1, rds[s], wrs[s]) || hits(de_rs2, use_rs2, rds[s], wrs[s]))
                raw = 1;
        return FWD_EN ? lu : (lu || (de_ce && raw));
    endfunction

    function automatic int exp_fwd(input logic [AWIDTH-1:0] rs);
        if (!FWD_EN) return 0;
        if (mem_we && mem_rd != 0 && mem_rd == rs) return 1;
        if (wb_we && wb_rd != 0 && wb_rd == rs) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin : model_cmp
        int e_sif, e_sde, e_sex, e_fde, e_fex, e_to, e_f1, e_f2, e_st;
        int this_count;
        bit hazard, req_wait, pend_now;
        e_sif = 0; e_sde = 0; e_sex = 0; e_fde = 0; e_fex = 0;
        e_to = 0; e_f1 = 0; e_f2 = 0; e_st = 0;
        n_stalls = m_stalls; n_flush_left = m_flush_left; n_pend = m_pend;
        if (rst) begin
            n_stalls = 0; n_flush_left = 0; n_pend = 0;
        end else begin
            e_f1 = exp_fwd(ex_rs1);
            e_f2 = exp_fwd(ex_rs2);
            if (m_stalls > 0) begin
                e_st = 1; e_sif = 1; e_sde = 1; e_sex = 1;
                this_count = m_stalls + 1;
                pend_now = m_pend || change_pc;
                if (mem_ack || this_count == MEM_TIMEOUT) begin
                    e_to = !mem_ack;
                    n_stalls = 0;
                    n_pend = 0;
                    n_flush_left = pend_now ? FLUSH_CYCLES : 0;
                end else begin
                    n_stalls = this_count;
                    n_pend = pend_now;
                end
            end else if (m_flush_left > 0) begin
                e_st = 2; e_fde = 1; e_fex = 1;
                n_flush_left = change_pc ? FLUSH_CYCLES : m_flush_left - 1;
            end else begin
                req_wait = mem_req && !mem_ack;
                hazard = exp_bubble();
                e_sif = req_wait || hazard;
                e_sde = req_wait || hazard;
                e_sex = req_wait;
                e_fex = hazard && !req_wait;
                if (req_wait) begin
                    n_stalls = 1;
                    n_pend = 0;
                end else if (change_pc) begin
                    n_flush_left = FLUSH_CYCLES;
                end
            end
        end
        chk("stall_if", stall_if, e_sif);
        chk("stall_de", stall_de, e_sde);
        chk("stall_ex", stall_ex, e_sex);
        chk("flush_de", flush_de, e_fde);
        chk("flush_ex", flush_ex, e_fex);
        chk("timeout",  timeout,  e_to);
        chk("fwd_rs1",  fwd_rs1,  e_f1);
        chk("fwd_rs2",  fwd_rs2,  e_f2);
        chk("state",    state,    e_st);
    end

    always @(posedge clk) begin
        m_stalls     <= n_stalls;
        m_flush_left <= n_flush_left;
        m_pend       <= n_pend;
    end

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        int n_st, n_to, to_at;
        logic [4:0] pat;
        int t_req[7] = '{1, 0, 0, 0, 0, 0, 0};
        int t_cpc[7] = '{0, 1, 0, 0, 0, 0, 0};
        int t_ack[7] = '{0, 0, 0, 1, 0, 0, 0};
        int t_st[7]  = '{0, 1, 1, 1, 2, 2, 0};

        // Reset with arbitrary inputs: everything low.
        rst = 1;
        drive_random(1'b1);
        mem_req = 1; change_pc = 1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", {outs(), fwd_rs1, fwd_rs2, state}, 0);
        end
        next_cycle();
        rst = 0;
        drive_idle();
        repeat (2) begin
            @(negedge clk);
            chk("idle_outs", {outs(), fwd_rs1, fwd_rs2, state}, 0);
        end

        // Load-use on rs1 = 5: one bubble while the hazard is present.
        next_cycle();
        ex_ce = 1; ex_op = LOAD_WORD; ex_rd = 5; ex_we = 1;
        de_ce = 1; de_rs1 = 5; use_rs1 = 1;
        @(negedge clk);
        chk("load_use", outs(), 6'b110010);
        next_cycle();
        ex_ce = 0;
        @(negedge clk);
        chk("load_use_gone", outs(), 0);
        next_cycle();
        ex_ce = 1; ex_rd = 0; de_rs1 = 0;
        @(negedge clk);
        chk("load_use_rd0", outs(), 0);

        // Forwarding priority MEM over WB on rs2 = 3.
        next_cycle();
        drive_idle();
        ex_ce = 1; ex_rs2 = 3; mem_rd = 3; mem_we = 1; wb_rd = 3; wb_we = 1;
        @(negedge clk);
        chk("fwd_mem_prio", fwd_rs2, FWD_EN ? 1 : 0);
        next_cycle();
        mem_we = 0;
        @(negedge clk);
        chk("fwd_wb", fwd_rs2, FWD_EN ? 2 : 0);

        // Memory timeout with ack held low.
        next_cycle();
        drive_idle();
        mem_req = 1;
        n_st = 0; n_to = 0; to_at = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (stall_ex) n_st++;
            if (timeout) begin n_to++; to_at = i; end
            next_cycle();
            mem_req = 0;
        end
        chk("timeout_stalls", n_st, MEM_TIMEOUT);
        chk("timeout_pulses", n_to, 1);
        chk("timeout_cycle", to_at, 15);
        @(negedge clk);
        chk("timeout_state", state, 0);

        // PC change pulse: flush in exactly the two following cycles.
        next_cycle();
        change_pc = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pat[i] = flush_de && flush_ex;
            next_cycle();
            change_pc = 0;
        end
        chk("flush_window", pat, 5'b00110);

        // PC change during a memory wait, ack three cycles after the request.
        for (int i = 0; i < 7; i++) begin
            mem_req = t_req[i][0]; change_pc = t_cpc[i][0]; mem_ack = t_ack[i][0];
            @(negedge clk);
            chk("wait_then_flush", state, t_st[i]);
            next_cycle();
        end
        drive_idle();

        // ADD RAW on WB rd = 7.
        ex_ce = 1; ex_op = OP_ADD; ex_rd = 2; ex_we = 1;
        de_ce = 1; de_rs1 = 7; use_rs1 = 1; wb_rd = 7; wb_we = 1;
        @(negedge clk);
        chk("raw_wb_stall", outs(), FWD_EN ? 6'b000000 : 6'b110010);
        chk("raw_wb_fwd", {fwd_rs1, fwd_rs2}, 0);
        next_cycle();
        wb_we = 0;
        @(negedge clk);
        chk("raw_wb_gone", outs(), 0);

        // Randomized traffic against the model, with ack-free windows and
        // occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            drive_random((c % 200) >= 40);
            if (c % 1000 == 500) rst = 1;
            if (c % 1000 == 502) rst = 0;
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
